// File: rtl/spi_reg_writer.sv
// SPI byte stream to SID register write commands, buffered in a small FIFO.
// Define SPI_REG_BURST_EN for auto-incrementing burst writes until SEL drops.
module spi_reg_writer #(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SEL,
  input  logic [7:0] RX_DATA,
  input  logic       RX_RECV,
  output logic [4:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic       WR_VALID,
  input  logic       WR_READY,
  output logic       OVF,
  output logic       BAD_CMD
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    IDLE,
    DATA
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [4:0]    addr_q;
  logic [4:0]    addr_nxt;
  logic [12:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic rx_ok;
  logic full;
  logic pop;
  logic push_req;
  logic push;
  logic ovf_d;
  logic bad_d;

  assign WR_VALID = (count != '0);
  assign WR_ADDR  = mem[rd_ptr][12:8];
  assign WR_DATA  = mem[rd_ptr][7:0];

  // Bytes arriving while deselected are discarded outright.
  assign rx_ok    = SEL & RX_RECV;
  assign full     = (count == FULL_CNT);
  assign pop      = WR_VALID & WR_READY;
  assign push_req = (state == DATA) & rx_ok;
  assign push     = push_req & (~full | pop);
  assign ovf_d    = push_req & full & ~pop;
  assign bad_d    = (state == IDLE) & rx_ok & ~RX_DATA[7];

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    if (!SEL) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (RX_RECV && RX_DATA[7]) begin
            addr_nxt  = RX_DATA[4:0];
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (RX_RECV) begin
`ifdef SPI_REG_BURST_EN
            addr_nxt  = addr_q + 5'd1;
            state_nxt = DATA;
`else
            state_nxt = IDLE;
`endif
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      addr_q  <= '0;
      OVF     <= 1'b0;
      BAD_CMD <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      OVF     <= ovf_d;
      BAD_CMD <= bad_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; WR_VALID masks stale entries.
  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= {addr_q, RX_DATA};
  end

endmodule
